// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath width, boot/bubble constants, base
// opcodes used by fetch, decode and hazard detection, and the fetch FSM states.
package riscv_pkg;

  localparam int          XLEN         = 32;
  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;

  // Opcode field [6:0]
  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_ADDI  = 7'b0010011;
  localparam logic [6:0] OPC_LW    = 7'b0000011;
  localparam logic [6:0] OPC_SW    = 7'b0100011;
  localparam logic [6:0] OPC_SB    = 7'b1100011;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_NOP   = 7'b0000000;

  typedef enum logic [1:0] {BOOT, RUN, SKID} if_state_t;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {pc, instr, valid} holding register for the fetch stage.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   load                capture pc_in/instr_in (entry becomes valid)
//   clear               entry consumed by IF/ID
//   flush               entry squashed by a redirect
//   pc_in, instr_in     entry payload
//   valid, pc, instr    current entry
module if_skid_buf
  import riscv_pkg::*;
#(
  parameter int XLEN_P = XLEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic              flush,
  input  logic [XLEN_P-1:0] pc_in,
  input  logic [31:0]       instr_in,
  output logic              valid,
  output logic [XLEN_P-1:0] pc,
  output logic [31:0]       instr
);

  logic              valid_q, valid_d;
  logic [XLEN_P-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;

  // Emptying wins over a same-cycle load; the FSM never asks for both.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear || flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = pc_in;
      instr_d = instr_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid = valid_q;
  assign pc    = pc_q;
  assign instr = instr_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, synchronous imem address drive,
// IF/ID pipeline register and a one-entry skid buffer.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   pc_write              PC may advance (hazard unit)
//   if_id_write           IF/ID may load (hazard unit)
//   redirect_valid/_pc    taken branch/jump target from EX
//   imem_addr             next fetch address (memory registers it)
//   imem_rdata            instruction at pc_q (one cycle after address)
//   id_valid, id_pc, id_pc_plus4, id_instr   IF/ID register to decode
module if_stage
  import riscv_pkg::*;
#(
  parameter int          XLEN         = riscv_pkg::XLEN,
  parameter logic [31:0] RESET_PC     = riscv_pkg::RESET_PC,
  parameter logic [31:0] BUBBLE_INSTR = riscv_pkg::BUBBLE_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_write,
  input  logic            if_id_write,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic [31:0]     id_instr
);

  if_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [XLEN-1:0] id_pc_plus4_q, id_pc_plus4_d;
  logic [31:0]     id_instr_q, id_instr_d;

  logic            skid_load, skid_clear, skid_flush;
  logic            skid_valid;
  logic [XLEN-1:0] skid_pc;
  logic [31:0]     skid_instr;

  logic [XLEN-1:0] pc_inc, redir_tgt;

  assign pc_inc    = pc_q + XLEN'(4);            // wraps modulo 2^XLEN
  assign redir_tgt = redirect_pc & ~XLEN'(3);    // force word alignment

  if_skid_buf #(.XLEN_P(XLEN)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (skid_load),
    .clear    (skid_clear),
    .flush    (skid_flush),
    .pc_in    (pc_q),
    .instr_in (imem_rdata),
    .valid    (skid_valid),
    .pc       (skid_pc),
    .instr    (skid_instr)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    id_valid_d    = id_valid_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_instr_d    = id_instr_q;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    skid_flush    = 1'b0;

    if (redirect_valid) begin
      // Squash whatever is in flight, including a parked skid entry.
      pc_d          = redir_tgt;
      id_valid_d    = 1'b0;
      id_pc_d       = '0;
      id_pc_plus4_d = '0;
      id_instr_d    = BUBBLE_INSTR;
      skid_flush    = 1'b1;
      state_d       = RUN;
    end else begin
      case (state_q)
        BOOT: begin
          // imem_rdata is not yet valid for pc_q: inject a bubble, hold PC.
          id_valid_d    = 1'b0;
          id_pc_d       = '0;
          id_pc_plus4_d = '0;
          id_instr_d    = BUBBLE_INSTR;
          state_d       = RUN;
        end
        RUN: begin
          if (if_id_write) begin
            id_valid_d    = 1'b1;
            id_pc_d       = pc_q;
            id_pc_plus4_d = pc_inc;
            id_instr_d    = imem_rdata;
            if (pc_write) pc_d = pc_inc;
          end else if (pc_write) begin
            // PC moves on while IF/ID is held: park the current fetch.
            skid_load = 1'b1;
            pc_d      = pc_inc;
            state_d   = SKID;
          end
        end
        SKID: begin
          // PC stays put so imem_rdata for pc_q is still valid on release.
          if (if_id_write) begin
            id_valid_d    = skid_valid;
            id_pc_d       = skid_pc;
            id_pc_plus4_d = skid_pc + XLEN'(4);
            id_instr_d    = skid_instr;
            skid_clear    = 1'b1;
            state_d       = RUN;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  assign imem_addr = rst_n ? pc_d : XLEN'(RESET_PC);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= XLEN'(RESET_PC);
      id_valid_q    <= 1'b0;
      id_pc_q       <= '0;
      id_pc_plus4_q <= '0;
      id_instr_q    <= BUBBLE_INSTR;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_valid_q    <= id_valid_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_instr_q    <= id_instr_d;
    end
  end

  assign id_valid    = id_valid_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_plus4_q;
  assign id_instr    = id_instr_q;

endmodule
